// File: rtl/conv3x3_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 register array turn a
// raster-order pixel stream into every fully-populated neighbourhood of the image.
module conv3x3_window_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 8,
    parameter int K      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_pixel,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [K*K*DATA_W-1:0]    win_data,
    output logic [4:0]               win_row,
    output logic [4:0]               win_col,
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic                   win_valid_q, win_valid_d;
    logic [K*K*DATA_W-1:0]  win_data_q, win_data_d;
    logic [4:0]             win_row_q, win_row_d;
    logic [4:0]             win_col_q, win_col_d;
    logic                   frame_done_q, frame_done_d;

    logic [DATA_W-1:0]      lb0_q [IMG_W];
    logic [DATA_W-1:0]      lb1_q [IMG_W];
    logic [DATA_W-1:0]      arr_q [K][K];

    logic                   accept;
    logic                   emit;
    logic                   last_col;
    logic                   last_row;
    logic [DATA_W-1:0]      new_col [K];
    logic [K*K*DATA_W-1:0]  win_next;

    assign in_ready   = !win_valid_q || win_ready;
    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

    always_comb begin
        accept   = rst && in_valid && in_ready;
        last_col = (col_q == CW'(IMG_W - 1));
        last_row = (row_q == RW'(IMG_H - 1));
        emit     = accept && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

        // Incoming right-hand column, top to bottom
        new_col[0] = lb1_q[col_q];
        new_col[1] = lb0_q[col_q];
        new_col[2] = in_pixel;

        win_next = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (c == K - 1)
                    win_next[(r*K+c)*DATA_W +: DATA_W] = new_col[r];
                else
                    win_next[(r*K+c)*DATA_W +: DATA_W] = arr_q[r][c+1];
            end
        end

        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = win_valid_q;
        win_data_d   = win_data_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = frame_done_q;

        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (emit) begin
            win_valid_d  = 1'b1;
            win_data_d   = win_next;
            win_row_d    = 5'(row_q - RW'(K - 1));
            win_col_d    = 5'(col_q - CW'(K - 1));
            frame_done_d = last_row && last_col;
        end else if (win_ready) begin
            win_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            win_data_q   <= win_data_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage is deliberately not reset: rows 0..1 refill it before any window is emitted
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_q[col_q] <= in_pixel;
            lb1_q[col_q] <= lb0_q[col_q];
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    if (c == K - 1)
                        arr_q[r][c] <= new_col[r];
                    else
                        arr_q[r][c] <= arr_q[r][c+1];
                end
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Bench for conv3x3_window_gen: an image-array model predicts every window from the
// accepted pixel stream; directed literals pin the first and last window of each frame.
module tb_conv3x3_window_gen;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pixel;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_data;
    logic [4:0]  win_row;
    logic [4:0]  win_col;
    logic        frame_done;

    conv3x3_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .K(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] data;
        int          r;
        int          c;
        bit          done;
    } win_t;

    int          checks = 0;
    int          errors = 0;
    win_t        exp_q[$];
    win_t        e_w;
    logic [7:0]  img [H][W];
    int          idx = 0;
    int          mr, mc;
    int          nwin = 0;
    int          nfd = 0;
    int          nacc = 0;
    int          first_acc = -1;
    logic [71:0] first_win = '0;
    logic [71:0] last_win = '0;
    bit          prev_stall = 0;
    logic [71:0] prev_data;
    logic [9:0]  prev_pos;
    logic        prev_done;
    int          base_w, base_fd;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model and compare process: outputs first, then record this cycle's accepted pixel
    always @(negedge clk) begin
        if (!rst) begin
            idx = 0;
            nacc = 0;
            prev_stall = 0;
            exp_q.delete();
        end else begin
            chk("in_ready", in_ready, !win_valid || win_ready);
            if (prev_stall) begin
                chk("hold_valid", win_valid, 1);
                chk("hold_data", win_data, prev_data);
                chk("hold_pos", {win_row, win_col}, prev_pos);
                chk("hold_done", frame_done, prev_done);
            end
            if (win_valid && win_ready) begin
                nwin++;
                if (frame_done) begin
                    nfd++;
                    last_win = win_data;
                end
                if (win_row == 0 && win_col == 0) begin
                    first_win = win_data;
                    first_acc = nacc;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window: got row %0d col %0d, expected no window", win_row, win_col);
                end else begin
                    e_w = exp_q.pop_front();
                    chk("win_data", win_data, e_w.data);
                    chk("win_row", win_row, e_w.r);
                    chk("win_col", win_col, e_w.c);
                    chk("frame_done", frame_done, e_w.done);
                end
            end
            prev_stall = win_valid && !win_ready;
            prev_data  = win_data;
            prev_pos   = {win_row, win_col};
            prev_done  = frame_done;
            if (in_valid && in_ready) begin
                mr = idx / W;
                mc = idx % W;
                img[mr][mc] = in_pixel;
                if (mr >= 2 && mc >= 2) begin
                    e_w.data = '0;
                    for (int rr = 0; rr < 3; rr++)
                        for (int cc = 0; cc < 3; cc++)
                            e_w.data[(rr*3+cc)*8 +: 8] = img[mr-2+rr][mc-2+cc];
                    e_w.r    = mr - 2;
                    e_w.c    = mc - 2;
                    e_w.done = (mr == H - 1) && (mc == W - 1);
                    exp_q.push_back(e_w);
                end
                idx = (idx + 1) % NPIX;
                nacc++;
            end
        end
    end

    task automatic stream(input int n, input int vpct, input int rpct, input int stall_at, input int ofs2);
        int sent = 0;
        int cyc = 0;
        int stall = 0;
        bit take;
        while (sent < n) begin
            if (cyc > n * 20 + 200) begin
                checks++;
                errors++;
                $display("FAIL stream_timeout: sent %0d pixels, required %0d", sent, n);
                break;
            end
            in_valid  = ($urandom_range(99) < vpct);
            in_pixel  = 8'(((sent % NPIX) + (sent / NPIX) * ofs2) % 256);
            win_ready = ($urandom_range(99) < rpct);
            if (sent == stall_at && stall < 5) begin
                win_ready = 1'b0;
                in_valid  = 1'b1;
                stall++;
            end
            @(negedge clk);
            take = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (take) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        win_ready = 1'b1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        win_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int exp_w, input int exp_fd);
        chk({tag, "_window_count"}, nwin - base_w, exp_w);
        chk({tag, "_frame_done_count"}, nfd - base_fd, exp_fd);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = 8'h00;
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_win_valid", win_valid, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_win_data", win_data, 0);
        chk("reset_win_pos", {win_row, win_col}, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b1;

        // Continuous full frame
        base_w = nwin; base_fd = nfd;
        stream(NPIX, 100, 100, -1, 0);
        drain();
        check_frame("t1", 676, 1);
        chk("t1_first_after_pixels", first_acc, 59);
        chk("t1_first_topleft", first_win[7:0], 0);
        chk("t1_first_centre", first_win[39:32], 29);
        chk("t1_first_bottomright", first_win[71:64], 58);
        chk("t1_last_topleft", last_win[7:0], 213);
        chk("t1_last_bottomright", last_win[71:64], 15);

        // Five-cycle downstream stall mid-row
        base_w = nwin; base_fd = nfd;
        stream(NPIX, 100, 100, 300, 0);
        drain();
        check_frame("t3", 676, 1);

        // Random input gaps and random downstream ready
        base_w = nwin; base_fd = nfd;
        stream(NPIX, 50, 50, -1, 0);
        drain();
        check_frame("t4", 676, 1);
        chk("t4_first_bottomright", first_win[71:64], 58);
        chk("t4_last_bottomright", last_win[71:64], 15);

        // Reset after a partial frame
        stream(100, 100, 100, -1, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_reset_win_valid", win_valid, 0);
        chk("t5_reset_win_data", win_data, 0);
        rst = 1'b1;
        base_w = nwin; base_fd = nfd;
        stream(NPIX, 100, 100, -1, 0);
        drain();
        check_frame("t5", 676, 1);
        chk("t5_first_after_pixels", first_acc, 59);
        chk("t5_first_topleft", first_win[7:0], 0);
        chk("t5_first_centre", first_win[39:32], 29);
        chk("t5_first_bottomright", first_win[71:64], 58);

        // Two frames back to back; second frame offset by 100
        base_w = nwin; base_fd = nfd;
        stream(2 * NPIX, 100, 100, -1, 100);
        drain();
        check_frame("t6", 1352, 2);
        chk("t6_f2_first_topleft", first_win[7:0], 100);
        chk("t6_f2_first_centre", first_win[39:32], 129);
        chk("t6_f2_first_bottomright", first_win[71:64], 158);
        chk("t6_f2_last_topleft", last_win[7:0], 57);
        chk("t6_f2_last_bottomright", last_win[71:64], 115);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
